// File: rtl/mdma_48bx512_ecc_ram.sv
// rtl/mdma_48bx512_ecc_ram.sv - 48B x 512 FIFO RAM with per-lane SECDED (72,64) ECC
// Read-first array, 1- or 2-cycle read pipeline, write-side error injection, saturating error counters.
module mdma_48bx512_ecc_ram #(
  parameter  int DEPTH      = 512,
  parameter  int DATA_BITS  = 384,
  parameter  int RD_LATENCY = 2,
  localparam int AW         = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [AW-1:0]        wadr,
  input  logic                 wen,
  input  logic [DATA_BITS-1:0] wdat,
  input  logic                 ren,
  input  logic [AW-1:0]        radr,
  output logic [DATA_BITS-1:0] rdat,
  output logic                 rsbe,
  output logic                 rdbe,
  input  logic                 inj_sbe,
  input  logic                 inj_dbe,
  output logic [15:0]          sbe_cnt,
  output logic [15:0]          dbe_cnt
);
  localparam int NL = DATA_BITS / 64;
  localparam int CW = NL * 72;

  // Lane layout: {overall parity, hamming[6:0], data[63:0]}; data bits occupy
  // the non-power-of-two positions 3..71 of the Hamming code in ascending order.
  function automatic logic [71:0] ecc_enc(input logic [63:0] d);
    logic [6:0] c;
    int         di;
    c  = '0;
    di = 0;
    for (int p = 1; p < 72; p++) begin
      if ((p & (p - 1)) != 0) begin
        if (d[di]) c = c ^ p[6:0];
        di = di + 1;
      end
    end
    return {^{c, d}, c, d};
  endfunction

  // Returns {dbe, sbe, corrected data}.
  function automatic logic [65:0] ecc_dec(input logic [71:0] cw);
    logic [63:0] d;
    logic [6:0]  s;
    logic        perr;
    int          di;
    d    = cw[63:0];
    s    = cw[70:64];
    perr = ^cw;
    di   = 0;
    for (int p = 1; p < 72; p++) begin
      if ((p & (p - 1)) != 0) begin
        if (cw[di]) s = s ^ p[6:0];
        di = di + 1;
      end
    end
    di = 0;
    for (int p = 1; p < 72; p++) begin
      if ((p & (p - 1)) != 0) begin
        if (perr && (s == p[6:0])) d[di] = ~d[di];
        di = di + 1;
      end
    end
    return {(!perr && (s != 7'd0)), perr, d};
  endfunction

  logic [CW-1:0] mem [DEPTH];
  logic [CW-1:0] wr_word;
  logic [CW-1:0] arr_word;
  logic          wr_ok;
  logic          rd_ok;

  assign wr_ok = wen && (32'(wadr) < DEPTH);
  assign rd_ok = (32'(radr) < DEPTH);

  always_comb begin
    wr_word = '0;
    for (int l = 0; l < NL; l++) wr_word[l*72 +: 72] = ecc_enc(wdat[l*64 +: 64]);
    if (inj_dbe)      wr_word[1:0] = ~wr_word[1:0];
    else if (inj_sbe) wr_word[0]   = ~wr_word[0];
  end

  always_ff @(posedge clk) begin
    if (wr_ok) mem[wadr] <= wr_word;
  end

  // An all-zero word is a valid codeword, so out-of-range reads decode to 0 with no flags.
  assign arr_word = rd_ok ? mem[radr] : '0;

  logic [CW-1:0] dec_in;
  logic          dec_vld;

  if (RD_LATENCY == 1) begin : g_lat1
    assign dec_in  = arr_word;
    assign dec_vld = ren;
  end else begin : g_lat2
    logic [CW-1:0] s1_word_q;
    logic          s1_vld_q;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        s1_vld_q  <= 1'b0;
        s1_word_q <= '0;
      end else begin
        s1_vld_q <= ren;
        if (ren) s1_word_q <= arr_word;
      end
    end
    assign dec_in  = s1_word_q;
    assign dec_vld = s1_vld_q;
  end

  logic [DATA_BITS-1:0] dec_data;
  logic [NL-1:0]        lane_sbe;
  logic [NL-1:0]        lane_dbe;

  always_comb begin
    logic [65:0] r;
    dec_data = '0;
    lane_sbe = '0;
    lane_dbe = '0;
    for (int l = 0; l < NL; l++) begin
      r                    = ecc_dec(dec_in[l*72 +: 72]);
      dec_data[l*64 +: 64] = r[63:0];
      lane_sbe[l]          = r[64];
      lane_dbe[l]          = r[65];
    end
  end

  logic [DATA_BITS-1:0] rdat_q, rdat_d;
  logic                 rsbe_q, rsbe_d;
  logic                 rdbe_q, rdbe_d;
  logic [15:0]          sbe_cnt_q, sbe_cnt_d;
  logic [15:0]          dbe_cnt_q, dbe_cnt_d;

  always_comb begin
    rdat_d    = dec_vld ? dec_data : rdat_q;
    rsbe_d    = dec_vld && (|lane_sbe) && !(|lane_dbe);
    rdbe_d    = dec_vld && (|lane_dbe);
    sbe_cnt_d = (rsbe_q && (sbe_cnt_q != 16'hFFFF)) ? sbe_cnt_q + 16'd1 : sbe_cnt_q;
    dbe_cnt_d = (rdbe_q && (dbe_cnt_q != 16'hFFFF)) ? dbe_cnt_q + 16'd1 : dbe_cnt_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdat_q    <= '0;
      rsbe_q    <= 1'b0;
      rdbe_q    <= 1'b0;
      sbe_cnt_q <= '0;
      dbe_cnt_q <= '0;
    end else begin
      rdat_q    <= rdat_d;
      rsbe_q    <= rsbe_d;
      rdbe_q    <= rdbe_d;
      sbe_cnt_q <= sbe_cnt_d;
      dbe_cnt_q <= dbe_cnt_d;
    end
  end

  assign rdat    = rdat_q;
  assign rsbe    = rsbe_q;
  assign rdbe    = rdbe_q;
  assign sbe_cnt = sbe_cnt_q;
  assign dbe_cnt = dbe_cnt_q;
endmodule

// File: tb/tb_mdma_48bx512_ecc_ram.sv
// tb/tb_mdma_48bx512_ecc_ram.sv - scoreboard bench for mdma_48bx512_ecc_ram
// Driver pushes expected read returns; a negedge monitor pops and compares on each return.
module tb_mdma_48bx512_ecc_ram;
  logic         clk = 1'b0;
  logic         rst_n;
  logic [8:0]   wadr, radr;
  logic         wen, ren, inj_sbe, inj_dbe;
  logic [383:0] wdat, rdat;
  logic         rsbe, rdbe;
  logic [15:0]  sbe_cnt, dbe_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  logic [385:0] exp_q [$];
  logic [383:0] m_dat [512];
  bit           m_sbe [512];
  bit           m_dbe [512];
  logic         vld_d1, vld_d2;

  mdma_48bx512_ecc_ram dut (
    .clk(clk), .rst_n(rst_n), .wadr(wadr), .wen(wen), .wdat(wdat),
    .ren(ren), .radr(radr), .rdat(rdat), .rsbe(rsbe), .rdbe(rdbe),
    .inj_sbe(inj_sbe), .inj_dbe(inj_dbe), .sbe_cnt(sbe_cnt), .dbe_cnt(dbe_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [383:0] act, input logic [383:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Two-cycle return timing of the reads the bench issued.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_d1 <= 1'b0;
      vld_d2 <= 1'b0;
    end else begin
      vld_d1 <= ren;
      vld_d2 <= vld_d1;
    end
  end

  always @(negedge clk) begin
    logic [385:0] e;
    if (rst_n === 1'b1) begin
      if (vld_d2) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_return: got a read return, expected none queued");
        end else begin
          e = exp_q.pop_front();
          chk("rdat", rdat, e[385:2]);
          chk("rsbe", 384'(rsbe), 384'(e[1]));
          chk("rdbe", 384'(rdbe), 384'(e[0]));
        end
      end else begin
        chk("idle_flags", 384'({rsbe, rdbe}), 384'(0));
      end
    end
  end

  task automatic op(input bit we, input int wa, input logic [383:0] wd,
                    input bit re, input int ra, input bit is = 1'b0, input bit id = 1'b0);
    @(negedge clk);
    wen = we; wadr = wa[8:0]; wdat = wd;
    ren = re; radr = ra[8:0]; inj_sbe = is; inj_dbe = id;
    if (re) exp_q.push_back({m_dat[ra], m_sbe[ra], m_dbe[ra]});
    if (we) begin
      m_dat[wa] = id ? (wd ^ 384'h3) : wd;
      m_sbe[wa] = is && !id;
      m_dbe[wa] = id;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) op(1'b0, 0, '0, 1'b0, 0);
  endtask

  task automatic drain;
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) idle(1);
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain_timeout: got %0d outstanding reads, expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  function automatic logic [383:0] pat(input int a);
    logic [63:0] l;
    l = {a[8:0], 55'h0};
    return {6{l}};
  endfunction

  initial begin
    logic [383:0] a_dat, b_dat, c_dat, ones;
    a_dat = {6{64'h0123_4567_89AB_CDEF}};
    b_dat = {6{64'hDEAD_BEEF_5A5A_A5A5}};
    c_dat = {6{64'h1357_9BDF_2468_ACE0}};
    ones  = '1;
    rst_n = 1'b0;
    wen = 1'b0; ren = 1'b0; wadr = '0; radr = '0; wdat = '0;
    inj_sbe = 1'b0; inj_dbe = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_rdat", rdat, '0);
    chk("reset_flags", 384'({rsbe, rdbe}), 384'(0));
    chk("reset_sbe_cnt", 384'(sbe_cnt), 384'(0));
    chk("reset_dbe_cnt", 384'(dbe_cnt), 384'(0));
    rst_n = 1'b1;

    op(1'b1, 5, a_dat, 1'b0, 0);
    op(1'b0, 0, '0, 1'b1, 5);
    drain();
    idle(2);
    chk("t1_sbe_cnt", 384'(sbe_cnt), 384'(0));
    chk("t1_dbe_cnt", 384'(dbe_cnt), 384'(0));

    for (int a = 0; a < 512; a++) op(1'b1, a, pat(a), 1'b0, 0);
    for (int a = 0; a < 512; a++) op(1'b0, 0, '0, 1'b1, a);
    drain();

    op(1'b1, 9, b_dat, 1'b1, 9);
    op(1'b0, 0, '0, 1'b1, 9);
    drain();

    op(1'b1, 20, ones, 1'b0, 0, 1'b1, 1'b0);
    op(1'b0, 0, '0, 1'b1, 20);
    drain();
    idle(2);
    chk("t4_sbe_cnt", 384'(sbe_cnt), 384'(1));
    chk("t4_dbe_cnt", 384'(dbe_cnt), 384'(0));

    op(1'b1, 21, '0, 1'b0, 0, 1'b1, 1'b1);
    op(1'b0, 0, '0, 1'b1, 21);
    drain();
    idle(2);
    chk("t5_sbe_cnt", 384'(sbe_cnt), 384'(1));
    chk("t5_dbe_cnt", 384'(dbe_cnt), 384'(1));

    op(1'b1, 30, c_dat, 1'b0, 0);
    op(1'b0, 0, '0, 1'b1, 20);
    op(1'b0, 0, '0, 1'b1, 21);
    idle(1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_rdat", rdat, '0);
    chk("rst_flags", 384'({rsbe, rdbe}), 384'(0));
    chk("rst_sbe_cnt", 384'(sbe_cnt), 384'(0));
    chk("rst_dbe_cnt", 384'(dbe_cnt), 384'(0));
    exp_q.delete();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    idle(4);
    op(1'b0, 0, '0, 1'b1, 30);
    drain();
    idle(2);
    chk("t6_sbe_cnt", 384'(sbe_cnt), 384'(0));
    chk("t6_dbe_cnt", 384'(dbe_cnt), 384'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got simulation still running, expected completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
    $fatal(1, "watchdog");
  end
endmodule
